// File: rtl/prog_loader_ctrl_pkg.sv
// Shared definitions for the UART program loader: FSM state
// encoding, UPG bus widths and the word-index to address mapping.
package prog_loader_ctrl_pkg;

   localparam int UPG_ADR_W    = 15;
   localparam int DMEM_SEL_BIT = 14;
   localparam int WORD_IDX_W   = 15;
   localparam int MAX_WORDS    = 32768;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR0 = 3'd1,
      ST_HDR1 = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   // Words at or past the end of instruction memory are rebased
   // into data memory, which is selected by the top address bit.
   function automatic logic [UPG_ADR_W-1:0] upg_addr(
      input logic [WORD_IDX_W-1:0] k,
      input int                    imem
   );
      logic [UPG_ADR_W-1:0] a;
      logic                 dmem;
      dmem = int'(k) >= imem;
      a    = dmem ? k - UPG_ADR_W'(imem) : k;
      a[DMEM_SEL_BIT] = dmem;
      return a;
   endfunction

endpackage

// File: rtl/prog_loader_ctrl_if.sv
// Byte-in / word-out bus of the program loader.
// Signals: rx_data_i, rx_valid_i (UART side), upg_wen_o, upg_adr_o, upg_dat_o (memory side).
interface prog_loader_ctrl_if;
   import prog_loader_ctrl_pkg::*;

   logic [7:0]           rx_data_i;
   logic                 rx_valid_i;
   logic                 upg_wen_o;
   logic [UPG_ADR_W-1:0] upg_adr_o;
   logic [31:0]          upg_dat_o;

   modport master (
      input  rx_data_i,
      input  rx_valid_i,
      output upg_wen_o,
      output upg_adr_o,
      output upg_dat_o
   );

   modport slave (
      output rx_data_i,
      output rx_valid_i,
      input  upg_wen_o,
      input  upg_adr_o,
      input  upg_dat_o
   );

endinterface

// File: rtl/prog_loader_ctrl_idle_timer.sv
// Counts idle cycles while enabled; expired pulses on the cycle whose edge
// would bring the count to LIMIT. Ports: clk, rst, clear, enable, expired.
module idle_timer #(
   parameter int LIMIT = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign expired = enable & ~clear & (cnt_q == W'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear | ~enable) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/prog_loader_ctrl.sv
// UART program loader: parses a 16-bit word count header, then packs little-endian
// bytes into 32-bit UPG memory writes. Ports: clk, rst, start_i, bus (rx in / upg out),
// upg_done_o, busy_o, err_o.
module prog_loader_ctrl
   import prog_loader_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 10000000,
   parameter int IMEM_WORDS     = 16384
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   prog_loader_ctrl_if.master bus,
   output logic               upg_done_o,
   output logic               busy_o,
   output logic               err_o
);

   state_e                state_q, state_d;
   logic [7:0]            nlo_q, nlo_d;
   logic [WORD_IDX_W-1:0] nm1_q, nm1_d;
   logic [WORD_IDX_W-1:0] word_q, word_d;
   logic [1:0]            byte_q, byte_d;
   logic [23:0]           asm_q, asm_d;
   logic                  wen_q, wen_d;
   logic [UPG_ADR_W-1:0]  adr_q, adr_d;
   logic [31:0]           dat_q, dat_d;
   logic                  done_q, busy_q, err_q;

   logic                  rx_v;
   logic [7:0]            rx_b;
   logic [15:0]           hdr_n;
   logic                  tmr_en;
   logic                  tmr_clr;
   logic                  tmo;

   assign rx_v  = bus.rx_valid_i;
   assign rx_b  = bus.rx_data_i;
   assign hdr_n = {rx_b, nlo_q};

   assign tmr_en  = (state_q == ST_HDR1) | (state_q == ST_DATA);
   // Any accepted byte or a restart restarts the idle window.
   assign tmr_clr = start_i | (rx_v & (tmr_en | (state_q == ST_HDR0)));

   idle_timer #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmr_clr),
      .enable (tmr_en),
      .expired(tmo)
   );

   always_comb begin
      state_d = state_q;
      nlo_d   = nlo_q;
      nm1_d   = nm1_q;
      word_d  = word_q;
      byte_d  = byte_q;
      asm_d   = asm_q;
      wen_d   = 1'b0;
      adr_d   = adr_q;
      dat_d   = dat_q;
      if (start_i) begin
         state_d = ST_HDR0;
         word_d  = '0;
         byte_d  = '0;
         asm_d   = '0;
      end else begin
         unique case (state_q)
            ST_HDR0: begin
               if (rx_v) begin
                  nlo_d   = rx_b;
                  state_d = ST_HDR1;
               end
            end
            ST_HDR1: begin
               if (rx_v) begin
                  nm1_d = WORD_IDX_W'(hdr_n - 16'd1);
                  if (hdr_n == 16'd0)
                     state_d = ST_DONE;
                  else if (int'(hdr_n) > MAX_WORDS)
                     state_d = ST_ERR;
                  else
                     state_d = ST_DATA;
               end else if (tmo) begin
                  state_d = ST_ERR;
               end
            end
            ST_DATA: begin
               if (rx_v) begin
                  byte_d = byte_q + 2'd1;
                  unique case (byte_q)
                     2'd0: asm_d[7:0]   = rx_b;
                     2'd1: asm_d[15:8]  = rx_b;
                     2'd2: asm_d[23:16] = rx_b;
                     default: begin
                        wen_d  = 1'b1;
                        dat_d  = {rx_b, asm_q};
                        adr_d  = upg_addr(word_q, IMEM_WORDS);
                        word_d = word_q + 1'b1;
                        if (word_q == nm1_q) state_d = ST_DONE;
                     end
                  endcase
               end else if (tmo) begin
                  state_d = ST_ERR;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         nlo_q   <= '0;
         nm1_q   <= '0;
         word_q  <= '0;
         byte_q  <= '0;
         asm_q   <= '0;
         wen_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         nlo_q   <= nlo_d;
         nm1_q   <= nm1_d;
         word_q  <= word_d;
         byte_q  <= byte_d;
         asm_q   <= asm_d;
         wen_q   <= wen_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         done_q  <= (state_d == ST_DONE);
         busy_q  <= (state_d == ST_HDR0) | (state_d == ST_HDR1) |
                    (state_d == ST_DATA);
         err_q   <= (state_d == ST_ERR);
      end
   end

   assign bus.upg_wen_o = wen_q;
   assign bus.upg_adr_o = adr_q;
   assign bus.upg_dat_o = dat_q;
   assign upg_done_o    = done_q;
   assign busy_o        = busy_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Testbench for prog_loader_ctrl: session-level model plus
// directed loads, header boundaries, timeout, restart and reset.
module tb_prog_loader_ctrl;

   localparam int TMO  = 100;
   localparam int IMEM = 16384;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic upg_done, busy, err;

   int tests = 0;
   int fails = 0;

   prog_loader_ctrl_if bus();

   prog_loader_ctrl #(
      .TIMEOUT_CYCLES(TMO),
      .IMEM_WORDS    (IMEM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start),
      .bus       (bus),
      .upg_done_o(upg_done),
      .busy_o    (busy),
      .err_o     (err)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: a session is a list of accepted bytes; the first two are
   // the count, each following group of four is one word.
   int         phase = 0;
   logic [7:0] q[$];
   int         silent = 0;
   int         n_words = 0;
   int         msz;
   int         mk;
   logic        e_wen = 1'b0;
   logic [14:0] e_adr = '0;
   logic [31:0] e_dat = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         phase = 0;
         q.delete();
         silent = 0;
         e_wen = 1'b0;
         e_adr = '0;
         e_dat = '0;
      end else begin
         e_wen = 1'b0;
         if (start) begin
            phase = 1;
            q.delete();
            silent = 0;
         end else if (phase == 1) begin
            if (bus.rx_valid_i) begin
               q.push_back(bus.rx_data_i);
               silent = 0;
               msz = q.size();
               if (msz == 2) begin
                  n_words = int'(q[0]) + 256 * int'(q[1]);
                  if (n_words == 0) phase = 2;
                  else if (n_words > 32768) phase = 3;
               end else if (msz > 2 && (msz - 2) % 4 == 0) begin
                  mk = (msz - 2) / 4 - 1;
                  e_wen = 1'b1;
                  e_adr = (mk >= IMEM) ? 15'(16384 + mk - IMEM) : 15'(mk);
                  e_dat = {q[msz-1], q[msz-2], q[msz-3], q[msz-4]};
                  if (mk == n_words - 1) phase = 2;
               end
            end else if (q.size() >= 1) begin
               silent++;
               if (silent >= TMO) phase = 3;
            end
         end
      end
   end

   logic [46:0] wlog[$];

   always @(negedge clk) begin
      if (bus.upg_wen_o) wlog.push_back({bus.upg_adr_o, bus.upg_dat_o});
      chk("cycle_outputs",
          {13'b0, bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o,
           upg_done, busy, err},
          {13'b0, e_wen, e_adr, e_dat,
           phase == 2, phase == 1, phase == 3});
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = b;
      @(posedge clk);
      #1 bus.rx_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_list(input logic [7:0] bl[$]);
      foreach (bl[i]) send_byte(bl[i]);
   endtask

   logic [31:0] w;

   initial begin
      bus.rx_valid_i = 1'b0;
      bus.rx_data_i  = 8'h00;
      #1 rst = 1'b1;
      idle(2);
      chk("reset_outputs",
          {bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o, upg_done, busy, err},
          '0);
      rst = 1'b0;
      idle(2);

      // basic two-word load
      wlog.delete();
      pulse_start();
      send_list('{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE});
      idle(2);
      chk("basic_nwrites", 64'(wlog.size()), 64'd2);
      if (wlog.size() == 2) begin
         chk("basic_w0", 64'(wlog[0]), {17'b0, 15'h0000, 32'h12345678});
         chk("basic_w1", 64'(wlog[1]), {17'b0, 15'h0001, 32'hDEADBEEF});
      end
      chk("basic_done", 64'({upg_done, busy, err}), 64'b100);

      // load spilling one word into data memory
      wlog.delete();
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h40);
      for (int k = 0; k < 16385; k++) begin
         w = 32'hC0DE0000 | 32'(k);
         send_byte(w[7:0]);
         send_byte(w[15:8]);
         send_byte(w[23:16]);
         send_byte(w[31:24]);
      end
      idle(2);
      chk("dmem_nwrites", 64'(wlog.size()), 64'd16385);
      if (wlog.size() == 16385) begin
         chk("dmem_last_imem", 64'(wlog[16383]),
             {17'b0, 15'h3FFF, 32'hC0DE3FFF});
         chk("dmem_first_dmem", 64'(wlog[16384]),
             {17'b0, 15'h4000, 32'hC0DE4000});
      end
      chk("dmem_done", 64'(upg_done), 64'd1);

      // zero-length header
      wlog.delete();
      pulse_start();
      send_list('{8'h00, 8'h00});
      idle(2);
      chk("n0_done", 64'({upg_done, busy, err}), 64'b100);
      chk("n0_nwrites", 64'(wlog.size()), 64'd0);

      // oversize header
      pulse_start();
      send_list('{8'h01, 8'h80});
      idle(2);
      chk("n32769_err", 64'({upg_done, busy, err}), 64'b001);
      chk("n32769_nwrites", 64'(wlog.size()), 64'd0);

      // timeout mid-word
      pulse_start();
      send_list('{8'h01, 8'h00, 8'hAA, 8'hBB});
      idle(99);
      chk("tmo_not_yet", 64'(err), 64'd0);
      idle(1);
      chk("tmo_err", 64'(err), 64'd1);
      chk("tmo_nwrites", 64'(wlog.size()), 64'd0);
      pulse_start();
      chk("tmo_restart", 64'({upg_done, busy, err}), 64'b010);

      // restart discards partial session
      send_list('{8'h01, 8'h00, 8'h11, 8'h22});
      pulse_start();
      send_list('{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11});
      idle(2);
      chk("restart_nwrites", 64'(wlog.size()), 64'd1);
      if (wlog.size() == 1)
         chk("restart_w0", 64'(wlog[0]), {17'b0, 15'h0000, 32'h11223344});
      chk("restart_done", 64'(upg_done), 64'd1);

      // reset in the middle of the second word
      wlog.delete();
      pulse_start();
      send_list('{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'h05, 8'h06});
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_outputs",
          {bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o, upg_done, busy, err},
          '0);
      idle(2);
      rst = 1'b0;
      wlog.delete();
      send_list('{8'h07, 8'h08, 8'h09, 8'h0A});
      idle(3);
      chk("post_rst_nwrites", 64'(wlog.size()), 64'd0);
      chk("post_rst_idle", 64'({upg_done, busy, err}), 64'b000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/prog_loader_ctrl.md
PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 10000000, meaning the maximum idle clock cycles allowed between accepted bytes mid-stream.
REQ-002 SHALL have parameter IMEM_WORDS, default 16384, meaning the word count of instruction memory; word indices at or above it target data memory.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, the UPG 10 MHz domain.
REQ-004 SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit: a one-cycle pulse that begins or restarts a load session.
REQ-006 SHALL have port rx_data_i, input, 8 bits: the received UART byte.
REQ-007 SHALL have port rx_valid_i, input, 1 bit: a one-cycle strobe marking rx_data_i as valid.
REQ-008 SHALL have port upg_wen_o, output, 1 bit: the memory write enable, asserted for one cycle per word.
REQ-009 SHALL have port upg_adr_o, output, 15 bits: the write address; bit 14 = 1 selects data memory, bits 13:0 are the word index.
REQ-010 SHALL have port upg_dat_o, output, 32 bits: the write data.
REQ-011 SHALL have port upg_done_o, output, 1 bit: high means the program is loaded and the CPU may run (kick-off).
REQ-012 SHALL have port busy_o, output, 1 bit: high while in HDR0, HDR1 or DATA.
REQ-013 SHALL have port err_o, output, 1 bit: high while in ERR.

Function
REQ-014 SHALL implement the states IDLE, HDR0, HDR1, DATA, DONE and ERR.
REQ-015 SHALL move from any state to HDR0 on start_i, clearing the byte counter, word counter, timer and assembly register; start_i has priority over a coincident rx_valid_i.
REQ-016 SHALL, in HDR0, latch rx_data_i as N[7:0] on the first accepted byte and move to HDR1.
REQ-017 SHALL, in HDR1, latch rx_data_i as N[15:8] on the accepted byte, then:
- N == 0 -> DONE
- N > 32768 -> ERR
- otherwise -> DATA
REQ-018 SHALL, in DATA, assemble each word little-endian: byte 0 -> [7:0], byte 1 -> [15:8], byte 2 -> [23:16], byte 3 -> [31:24].
REQ-019 SHALL, on the clock edge that accepts byte 3 of word k, register the following for exactly one cycle, visible the next cycle:
- upg_wen_o = 1
- upg_dat_o = the assembled word
- upg_adr_o = k, which places words k >= IMEM_WORDS in data memory via bit 14
REQ-020 SHALL keep accepting bytes during the upg_wen_o cycle; no byte is lost.
REQ-021 SHALL, when word N-1 is written, enter DONE on the same edge that raises upg_wen_o.
REQ-022 SHALL hold upg_done_o = 1 only in DONE.
REQ-023 SHALL, in HDR1 and DATA, increment a timer each cycle and zero it on every accepted byte; when the timer reaches TIMEOUT_CYCLES the block SHALL move to ERR, and no partial word is written.
REQ-024 SHALL ignore rx_valid_i in IDLE, DONE and ERR.
REQ-025 SHALL drive upg_wen_o = 0 in every cycle not covered by REQ-019.
REQ-026 SHALL hold upg_adr_o and upg_dat_o at their last written values between writes.

Reset
REQ-027 SHALL, on asserted rst, set state to IDLE and every output to 0 (upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o), and clear all counters, independent of clk.
REQ-028 SHALL, when rst asserts mid-session, abandon the session with no further write; after rst deasserts, a fresh start_i is required.

Structure
REQ-029 SHALL place the state encoding, the UPG address width (15) and the data-memory select bit index (14) in the shared defines package.
REQ-030 SHALL implement the timeout timer as one sub-module, idle_timer, with inputs clear and enable, parameter LIMIT, and output expired.

Verification
REQ-031 SHALL verify a basic load: start; bytes 02 00, then 78 56 34 12, then EF BE AD DE -> writes (adr 0x0000, 0x12345678) and (adr 0x0001, 0xDEADBEEF), then upg_done_o = 1.
REQ-032 SHALL verify data-memory targeting: N = 16385 -> the last write has upg_adr_o = 0x4000 (bit 14 set) and done follows.
REQ-033 SHALL verify header boundaries:
- header 00 00 -> DONE with no write
- header 01 80 (32769) -> err_o = 1 with no write
REQ-034 SHALL verify timeout: TIMEOUT_CYCLES = 100; N = 1; 2 data bytes, then silence -> err_o = 1 at 100 cycles after the last byte, no write; a following start_i clears err_o.
REQ-035 SHALL verify restart and reset:
- start_i after 2 data bytes -> header re-parsed, old bytes discarded
- rst mid-DATA -> all outputs 0 immediately, with no write afterwards
